// File: rtl/ram_sp_master.sv
// Single-request bus master for a synchronous single-port RAM with a shared data bus.
// It sequences chip select, output enable and bus turnaround so the requester only sees a simple valid/ready interface.
module ram_sp_master #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;
    logic                  req_in_range;
    logic                  addr_in_range;
    logic                  target_in_range;
    logic                  cs_next;
    logic                  we_next;
    logic                  oe_next;

    localparam bit DEPTH_IS_POW2 = (RAM_DEPTH == (1 << ADDR_WIDTH));

    // With a power-of-two depth every address is legal, so the compare is skipped entirely.
    generate
        if (DEPTH_IS_POW2) begin : g_full_range
            assign req_in_range  = 1'b1;
            assign addr_in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(RAM_DEPTH);
            assign req_in_range  = (req_addr < DEPTH_LIMIT);
            assign addr_in_range = (addr_q < DEPTH_LIMIT);
        end
    endgenerate

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign mem_data  = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

    // Controls are computed for the state being entered so the registered pins line up with it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_we ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = TURN;
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        target_in_range = (state == IDLE) ? req_in_range : addr_in_range;
        cs_next = ((state_next == WRITE) || (state_next == RD_ADDR) || (state_next == RD_DATA))
                  && target_in_range;
        we_next = (state_next == WRITE);
        oe_next = (state_next == RD_ADDR) || (state_next == RD_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_address <= '0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state  <= state_next;
            mem_cs <= cs_next;
            mem_we <= we_next;
            mem_oe <= oe_next;
            if (accept) begin
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                mem_address <= req_addr;
            end
            // The RAM is driving its registered word during RD_DATA; capture it as the response.
            rsp_valid <= (state == RD_DATA);
            rsp_err   <= (state == RD_DATA) && !addr_in_range;
            if (state == RD_DATA) begin
                rsp_rdata <= addr_in_range ? mem_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_master.sv
// Scoreboard bench for ram_sp_master: two masters (1024-word and 1000-word) each with a behavioural RAM.
// Stimulus pushes expected read responses; per-DUT monitors pop and compare on rsp_valid.
module tb_ram_sp_master;

    localparam int DW      = 8;
    localparam int AW      = 10;
    localparam int DEPTH_A = 1024;
    localparam int DEPTH_B = 1000;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_a, req_valid_b;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          req_ready_a, rsp_valid_a, rsp_err_a, mem_cs_a, mem_we_a, mem_oe_a;
    logic [DW-1:0] rsp_rdata_a;
    logic [AW-1:0] mem_address_a;
    wire  [DW-1:0] mem_data_a;

    logic          req_ready_b, rsp_valid_b, rsp_err_b, mem_cs_b, mem_we_b, mem_oe_b;
    logic [DW-1:0] rsp_rdata_b;
    logic [AW-1:0] mem_address_b;
    wire  [DW-1:0] mem_data_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rsp_cnt_a = 0;
    int cs_cnt_b  = 0;
    int we_run_a  = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    logic [DW-1:0] model_a [0:DEPTH_A-1];
    logic [DW-1:0] model_b [0:DEPTH_A-1];
    logic [DW-1:0] ram_a   [0:DEPTH_A-1];
    logic [DW-1:0] ram_b   [0:DEPTH_A-1];
    logic [DW-1:0] ram_q_a, ram_q_b;
    logic          ram_drive_a, ram_drive_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sp_master #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH_A)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .mem_address(mem_address_a), .mem_cs(mem_cs_a), .mem_we(mem_we_a),
        .mem_oe(mem_oe_a), .mem_data(mem_data_a)
    );

    ram_sp_master #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .mem_address(mem_address_b), .mem_cs(mem_cs_b), .mem_we(mem_we_b),
        .mem_oe(mem_oe_b), .mem_data(mem_data_b)
    );

    // Behavioural synchronous RAMs: write and read both registered on the clock edge.
    always @(posedge clk) begin
        if (mem_cs_a) begin
            if (mem_we_a) ram_a[mem_address_a] <= mem_data_a;
            else          ram_q_a <= ram_a[mem_address_a];
        end
        if (mem_cs_b) begin
            if (mem_we_b) ram_b[mem_address_b] <= mem_data_b;
            else          ram_q_b <= ram_b[mem_address_b];
        end
    end

    assign ram_drive_a = mem_cs_a && mem_oe_a && !mem_we_a;
    assign ram_drive_b = mem_cs_b && mem_oe_b && !mem_we_b;
    assign mem_data_a  = ram_drive_a ? ram_q_a : {DW{1'bz}};
    assign mem_data_b  = ram_drive_b ? ram_q_b : {DW{1'bz}};

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors: pop scoreboard on each response, watch write pulse width and bus ownership.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_a) begin
                rsp_cnt_a++;
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_a_unexpected: got rsp_valid=1, expected no response");
                end else begin
                    e_a = q_a.pop_front();
                    check_output("rsp_a_data", 32'(rsp_rdata_a), 32'(e_a.data));
                    check_output("rsp_a_err", 32'(rsp_err_a), 32'(e_a.err));
                    check_output("rsp_a_latency", 32'(cyc), 32'(e_a.cyc));
                end
            end
            if (rsp_valid_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_b_unexpected: got rsp_valid=1, expected no response");
                end else begin
                    e_b = q_b.pop_front();
                    check_output("rsp_b_data", 32'(rsp_rdata_b), 32'(e_b.data));
                    check_output("rsp_b_err", 32'(rsp_err_b), 32'(e_b.err));
                    check_output("rsp_b_latency", 32'(cyc), 32'(e_b.cyc));
                end
            end
            if (mem_we_a) begin
                we_run_a++;
            end else if (we_run_a != 0) begin
                check_output("mem_we_a_width", 32'(we_run_a), 32'd1);
                we_run_a = 0;
            end
            if (mem_cs_a || mem_cs_b) begin
                check_output("bus_contention", 32'((ram_drive_a && mem_we_a) || (ram_drive_b && mem_we_b)), 32'd0);
            end
            if (mem_cs_b) cs_cnt_b++;
        end
    end

    // Issue one request (called at a negedge); expected read data comes from the bench's own model.
    task automatic apply_stimulus(input bit sel_b, input bit we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input bit keep_valid);
        int   waits;
        exp_t e;
        bit   in_range;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel_b) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        waits = 0;
        while (!(sel_b ? req_ready_b : req_ready_a)) begin
            @(negedge clk);
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL req_ready_timeout: got ready=0 for %0d cycles, expected ready within 20", waits);
                req_valid_a = 1'b0;
                req_valid_b = 1'b0;
                return;
            end
        end
        in_range = sel_b ? (int'(addr) < DEPTH_B) : 1'b1;
        if (we) begin
            if (in_range) begin
                if (sel_b) model_b[addr] = wdata;
                else       model_a[addr] = wdata;
            end
        end else begin
            e.data = in_range ? (sel_b ? model_b[addr] : model_a[addr]) : '0;
            e.err  = !in_range;
            e.cyc  = cyc + 3;
            if (sel_b) q_b.push_back(e);
            else       q_a.push_back(e);
        end
        @(negedge clk);
        if (!keep_valid) begin
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req_ready"}, 32'(req_ready_a), 32'd1);
        check_output({tag, "_rsp_valid"}, 32'(rsp_valid_a), 32'd0);
        check_output({tag, "_rsp_err"}, 32'(rsp_err_a), 32'd0);
        check_output({tag, "_rsp_rdata"}, 32'(rsp_rdata_a), 32'd0);
        check_output({tag, "_mem_cs"}, 32'(mem_cs_a), 32'd0);
        check_output({tag, "_mem_we"}, 32'(mem_we_a), 32'd0);
        check_output({tag, "_mem_oe"}, 32'(mem_oe_a), 32'd0);
        check_output({tag, "_mem_address"}, 32'(mem_address_a), 32'd0);
        check_output({tag, "_ram_drive"}, 32'(ram_drive_a), 32'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout: got no finish by 200000, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int            base_cnt;
        int            waits;
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH_A; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
            ram_a[i]   = '0;
            ram_b[i]   = '0;
        end
        rst_n       = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write 0xA5 to addr 3, read back");
        apply_stimulus(0, 1, 10'd3, 8'hA5, 0);
        apply_stimulus(0, 0, 10'd3, 8'h00, 0);
        repeat (5) @(negedge clk);

        $display("[TB] reset asserted while read is in RD_DATA");
        req_we      = 1'b0;
        req_addr    = 10'd3;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        @(negedge clk);
        check_output("pre_reset_mem_oe", 32'(mem_oe_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midop");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        base_cnt = rsp_cnt_a;
        repeat (6) @(negedge clk);
        check_output("no_rsp_after_reset", 32'(rsp_cnt_a - base_cnt), 32'd0);

        $display("[TB] boundary addresses 0 and 1023");
        apply_stimulus(0, 1, 10'd0, 8'h11, 0);
        apply_stimulus(0, 1, 10'd1023, 8'hEE, 0);
        apply_stimulus(0, 0, 10'd0, 8'h00, 0);
        apply_stimulus(0, 0, 10'd1023, 8'h00, 0);

        $display("[TB] back-to-back alternating requests with req_valid held");
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(0, (k % 2) == 0, 10'(40 + k / 2), 8'(8'h30 + k), 1);
        end
        req_valid_a = 1'b0;

        $display("[TB] out-of-range access on 1000-word master");
        apply_stimulus(1, 1, 10'd1000, 8'h5A, 0);
        apply_stimulus(1, 0, 10'd1000, 8'h00, 0);
        apply_stimulus(1, 1, 10'd999, 8'h3C, 0);
        apply_stimulus(1, 0, 10'd999, 8'h00, 0);

        $display("[TB] fill and read back addresses 0..153");
        for (int j = 0; j < 154; j++) begin
            d = 8'($urandom(j) % 255);
            apply_stimulus(0, 1, 10'(j), d, 0);
        end
        for (int j = 0; j < 154; j++) begin
            apply_stimulus(0, 0, 10'(j), 8'h00, 0);
        end

        waits = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check_output("queue_a_drained", 32'(q_a.size()), 32'd0);
        check_output("queue_b_drained", 32'(q_b.size()), 32'd0);
        check_output("mem_cs_b_cycles", 32'(cs_cnt_b), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
